// File: rtl/uart_tx_bank_if.sv
// uart_tx_bank_if: shared configuration, per-channel handshake and serial lines of the UART transmitter bank
// Signals: div_i (bit period - 1), len_i (data bits, 0/over-range = DATA_W), stop2_i, parity_en_i, odd_i,
//          tx_data_i (channel k at [k*DATA_W +: DATA_W]), tx_valid_i/tx_ready_o (per-channel handshake),
//          txd_o (serial lines, idle 1), tx_done_o (pulse in the last stop-bit cycle).
// Modports: master drives requests and configuration, slave is the transmitter bank.
interface uart_tx_bank_if #(
    parameter int CHANNELS = 2,
    parameter int DATA_W   = 8,
    parameter int DIV_W    = 16
);
    logic [DIV_W-1:0]           div_i;
    logic [4:0]                 len_i;
    logic                       stop2_i;
    logic                       parity_en_i;
    logic                       odd_i;
    logic [CHANNELS*DATA_W-1:0] tx_data_i;
    logic [CHANNELS-1:0]        tx_valid_i;
    logic [CHANNELS-1:0]        tx_ready_o;
    logic [CHANNELS-1:0]        txd_o;
    logic [CHANNELS-1:0]        tx_done_o;
    modport master (
        output div_i, len_i, stop2_i, parity_en_i, odd_i, tx_data_i, tx_valid_i,
        input  tx_ready_o, txd_o, tx_done_o
    );
    modport slave (
        input  div_i, len_i, stop2_i, parity_en_i, odd_i, tx_data_i, tx_valid_i,
        output tx_ready_o, txd_o, tx_done_o
    );
endinterface

// File: rtl/uart_tx_bank.sv
// uart_tx_bank: bank of independent LSB-first UART transmitters with per-channel bit-rate counters
// Ports: m_clock (system clock), p_reset (async active-high reset), bus (uart_tx_bank_if.slave).
// Each channel latches data and configuration on accept, then sends start, 1..DATA_W data bits,
// an optional parity bit and one or two stop bits, each lasting div+1 cycles.
// Build option: define UART_TX_PARITY_EN to build the parity state; otherwise parity_en_i/odd_i are ignored.
module uart_tx_bank #(
    parameter int CHANNELS = 2,
    parameter int DATA_W   = 8,
    parameter int DIV_W    = 16
) (
    input logic             m_clock,
    input logic             p_reset,
    uart_tx_bank_if.slave   bus
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_STOP  = 3'd3;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] S_PAR   = 3'd4;
`else
    logic w_unused_par;
    assign w_unused_par = bus.parity_en_i ^ bus.odd_i;
`endif

    logic [4:0] w_len;
    assign w_len = (bus.len_i == 5'd0 || bus.len_i > 5'(DATA_W)) ? 5'(DATA_W) : bus.len_i;

    for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
        logic [2:0]        r_state, w_next;
        logic [DIV_W-1:0]  r_div, r_cnt;
        logic [4:0]        r_len, r_bit;
        logic [DATA_W-1:0] r_sh;
        logic              r_stop2;
        logic              w_tick, w_last_data, w_last_stop, w_txd, w_ready, w_done;
`ifdef UART_TX_PARITY_EN
        logic              r_par_en, r_odd, r_par;
`endif

        assign w_tick      = r_cnt == r_div;
        assign w_last_data = r_bit == r_len - 5'd1;
        assign w_last_stop = r_bit == {4'd0, r_stop2};

        always_ff @(posedge m_clock or posedge p_reset) begin
            if (p_reset) r_state <= S_IDLE;
            else         r_state <= w_next;
        end

        always_comb begin
            w_next = r_state;
            case (r_state)
                S_IDLE:  if (bus.tx_valid_i[k]) w_next = S_START;
                S_START: if (w_tick) w_next = S_DATA;
`ifdef UART_TX_PARITY_EN
                S_DATA:  if (w_tick && w_last_data) w_next = r_par_en ? S_PAR : S_STOP;
                S_PAR:   if (w_tick) w_next = S_STOP;
`else
                S_DATA:  if (w_tick && w_last_data) w_next = S_STOP;
`endif
                S_STOP:  if (w_tick && w_last_stop) w_next = S_IDLE;
                default: w_next = S_IDLE;
            endcase
        end

        always_comb begin
`ifdef UART_TX_PARITY_EN
            w_txd = r_state == S_START ? 1'b0 : r_state == S_DATA ? r_sh[0] :
                    r_state == S_PAR ? r_par ^ r_odd : 1'b1;
`else
            w_txd = r_state == S_START ? 1'b0 : r_state == S_DATA ? r_sh[0] : 1'b1;
`endif
            w_ready = r_state == S_IDLE;
            w_done  = r_state == S_STOP && w_tick && w_last_stop;
        end

        // bit counter restarts whenever the state changes, so it indexes data bits in DATA and stop bits in STOP
        always_ff @(posedge m_clock or posedge p_reset) begin
            if (p_reset) begin
                r_div   <= '0;
                r_cnt   <= '0;
                r_len   <= '0;
                r_bit   <= '0;
                r_sh    <= '0;
                r_stop2 <= 1'b0;
`ifdef UART_TX_PARITY_EN
                r_par_en <= 1'b0;
                r_odd    <= 1'b0;
                r_par    <= 1'b0;
`endif
            end else if (r_state == S_IDLE) begin
                if (bus.tx_valid_i[k]) begin
                    r_sh    <= bus.tx_data_i[k*DATA_W +: DATA_W];
                    r_div   <= bus.div_i;
                    r_len   <= w_len;
                    r_stop2 <= bus.stop2_i;
`ifdef UART_TX_PARITY_EN
                    r_par_en <= bus.parity_en_i;
                    r_odd    <= bus.odd_i;
`endif
                end
                r_cnt <= '0;
                r_bit <= '0;
`ifdef UART_TX_PARITY_EN
                r_par <= 1'b0;
`endif
            end else begin
                r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
                if (w_tick) begin
                    r_bit <= w_next == r_state ? r_bit + 5'd1 : 5'd0;
                    if (r_state == S_DATA) begin
                        r_sh <= r_sh >> 1;
`ifdef UART_TX_PARITY_EN
                        r_par <= r_par ^ r_sh[0];
`endif
                    end
                end
            end
        end

        assign bus.txd_o[k]      = w_txd;
        assign bus.tx_ready_o[k] = w_ready;
        assign bus.tx_done_o[k]  = w_done;
    end
endmodule

// File: tb/tb_uart_tx_bank.sv
// tb_uart_tx_bank: scoreboard bench for uart_tx_bank; expected frames are queued at accept and checked cycle by cycle
module tb_uart_tx_bank;
    localparam int CH = 2;
    localparam int DW = 8;
    localparam int VW = 16;

    typedef struct {
        logic [31:0] bits;
        int          n;
        int          div;
    } frame_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    uart_tx_bank_if #(.CHANNELS(CH), .DATA_W(DW), .DIV_W(VW)) bus();
    uart_tx_bank #(.CHANNELS(CH), .DATA_W(DW), .DIV_W(VW)) dut (
        .m_clock (clk),
        .p_reset (rst),
        .bus     (bus)
    );

    frame_t sb0[$];
    frame_t sb1[$];
    int     checks = 0;
    int     failures = 0;
    int     cyc = 0;
    bit     active[CH];
    int     c[CH];
    frame_t cur[CH];
    int     start_cyc[CH];
    int     done_cyc[CH];
    int     gap[CH];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic frame_t mk(input logic [15:0] d, input int len, input bit s2,
                                  input bit pe, input bit od, input int div);
        frame_t f;
        int     n;
        int     i;
        bit     p;
        n = (len == 0 || len > DW) ? DW : len;
        f.bits = '1;
        f.bits[0] = 1'b0;
        p = 1'b0;
        i = 1;
        for (int b = 0; b < n; b++) begin
            f.bits[i] = d[b];
            p ^= d[b];
            i++;
        end
`ifdef UART_TX_PARITY_EN
        if (pe) begin
            f.bits[i] = p ^ od;
            i++;
        end
`else
        if (pe && od && p) f.bits[0] = 1'b0;
`endif
        i += s2 ? 2 : 1;
        f.n = i;
        f.div = div;
        return f;
    endfunction

    always @(negedge clk) begin
        int depth;
        int last;
        cyc++;
        for (int ch = 0; ch < CH; ch++) begin
            if (rst) begin
                active[ch] = 1'b0;
                if (ch == 0) sb0.delete();
                else sb1.delete();
            end else begin
                if (!active[ch] && !bus.tx_ready_o[ch]) begin
                    depth = ch == 0 ? sb0.size() : sb1.size();
                    chk($sformatf("sb_depth%0d", ch), depth, 1);
                    if (depth > 0) begin
                        if (ch == 0) cur[ch] = sb0.pop_front();
                        else cur[ch] = sb1.pop_front();
                        active[ch] = 1'b1;
                        c[ch] = 0;
                        start_cyc[ch] = cyc;
                        gap[ch] = cyc - done_cyc[ch];
                    end
                end
                if (active[ch]) begin
                    last = cur[ch].n * (cur[ch].div + 1) - 1;
                    chk($sformatf("txd%0d", ch), bus.txd_o[ch], cur[ch].bits[c[ch] / (cur[ch].div + 1)]);
                    chk($sformatf("done%0d", ch), bus.tx_done_o[ch], c[ch] == last);
                    chk($sformatf("ready%0d", ch), bus.tx_ready_o[ch], 0);
                    if (c[ch] == last) begin
                        active[ch] = 1'b0;
                        done_cyc[ch] = cyc;
                    end
                    c[ch]++;
                end else begin
                    chk($sformatf("idle_txd%0d", ch), bus.txd_o[ch], 1);
                    chk($sformatf("idle_done%0d", ch), bus.tx_done_o[ch], 0);
                end
            end
        end
    end

    task automatic scramble();
        bus.div_i   = 16'($urandom_range(0, 9));
        bus.len_i   = 5'($urandom_range(0, 31));
        bus.stop2_i = 1'($urandom);
        bus.parity_en_i = 1'($urandom);
        bus.odd_i   = 1'($urandom);
    endtask

    task automatic send(input int ch, input logic [15:0] d, input int div, input int len,
                        input bit s2, input bit pe, input bit od, input bit hold);
        int n = 0;
        bus.tx_data_i[ch*DW +: DW] = d[DW-1:0];
        bus.div_i = 16'(div);
        bus.len_i = 5'(len);
        bus.stop2_i = s2;
        bus.parity_en_i = pe;
        bus.odd_i = od;
        bus.tx_valid_i[ch] = 1'b1;
        while (!bus.tx_ready_o[ch] && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("accept_wait", bus.tx_ready_o[ch], 1);
        @(posedge clk);
        if (ch == 0) sb0.push_back(mk(d, len, s2, pe, od, div));
        else sb1.push_back(mk(d, len, s2, pe, od, div));
        #1;
        if (!hold) bus.tx_valid_i[ch] = 1'b0;
        bus.tx_data_i[ch*DW +: DW] = DW'($urandom);
        scramble();
    endtask

    task automatic send2(input logic [15:0] d0, input logic [15:0] d1, input int div, input int len);
        int n = 0;
        bus.tx_data_i = {d1[DW-1:0], d0[DW-1:0]};
        bus.div_i = 16'(div);
        bus.len_i = 5'(len);
        bus.stop2_i = 1'b0;
        bus.parity_en_i = 1'b0;
        bus.odd_i = 1'b0;
        bus.tx_valid_i = 2'b11;
        while (bus.tx_ready_o != 2'b11 && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("accept2_wait", bus.tx_ready_o, 2'b11);
        @(posedge clk);
        sb0.push_back(mk(d0, len, 1'b0, 1'b0, 1'b0, div));
        sb1.push_back(mk(d1, len, 1'b0, 1'b0, 1'b0, div));
        #1;
        bus.tx_valid_i = 2'b00;
        scramble();
    endtask

    task automatic wait_idle();
        int n = 0;
        bit busy;
        do begin
            @(posedge clk);
            #1;
            n++;
            busy = active[0] || active[1] || sb0.size() != 0 || sb1.size() != 0;
        end while (busy && n < 3000);
        chk("idle_timeout", busy, 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.div_i = '0;
        bus.len_i = 5'd8;
        bus.stop2_i = 1'b0;
        bus.parity_en_i = 1'b0;
        bus.odd_i = 1'b0;
        bus.tx_data_i = '0;
        bus.tx_valid_i = '0;
        for (int i = 0; i < CH; i++) begin
            active[i] = 1'b0;
            done_cyc[i] = 0;
        end
        #2 rst = 1'b1;
        @(negedge clk);
        chk("rst_txd", bus.txd_o, 2'b11);
        chk("rst_ready", bus.tx_ready_o, 2'b11);
        chk("rst_done", bus.tx_done_o, 2'b00);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        send(0, 16'h38, 3, 8, 1'b0, 1'b0, 1'b0, 1'b0);
        wait_idle();
        send(1, 16'hFF, 0, 5, 1'b1, 1'b0, 1'b0, 1'b0);
        wait_idle();
        send(0, 16'h39, 2, 8, 1'b0, 1'b1, 1'b1, 1'b0);
        wait_idle();
        send(0, 16'h39, 2, 8, 1'b0, 1'b1, 1'b0, 1'b0);
        wait_idle();

        send2(16'h38, 16'h39, 1, 8);
        wait_idle();
        chk("start_align", start_cyc[0], start_cyc[1]);

        send(0, 16'hA5, 1, 8, 1'b0, 1'b0, 1'b0, 1'b1);
        send(0, 16'h3C, 1, 6, 1'b1, 1'b0, 1'b0, 1'b1);
        bus.tx_valid_i[0] = 1'b0;
        wait_idle();
        chk("b2b_gap", gap[0], 2);

        send(1, 16'h38, 3, 8, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (12) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort_txd", bus.txd_o, 2'b11);
        chk("abort_ready", bus.tx_ready_o, 2'b11);
        chk("abort_done", bus.tx_done_o, 2'b00);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        send(1, 16'h55, 2, 8, 1'b0, 1'b0, 1'b0, 1'b0);
        wait_idle();

        send(0, 16'hC3, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        wait_idle();
        send(1, 16'h6B, 0, 20, 1'b1, 1'b1, 1'b1, 1'b0);
        wait_idle();
        for (int i = 0; i < 8; i++) begin
            send($urandom_range(0, 1), 16'($urandom), $urandom_range(0, 3), $urandom_range(0, 31),
                 1'($urandom), 1'($urandom), 1'($urandom), 1'b0);
            wait_idle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
